// File: rtl/fifo_event_unpacker.sv
// fifo_event_unpacker
// Drains the digitizer's 16-bit global output FIFO, parses it into records
// (one header word followed by HOWMANY zero-extended samples) and repacks each
// record into 32-bit stream beats with end-of-record marking, a completed
// record counter and a sticky stall-timeout flag.
module fifo_event_unpacker #(
  parameter int         SIZE    = 8,
  parameter int         WIDTH   = 12,
  parameter int         TIMEOUT = 1024,
  parameter logic [7:0] MAGIC   = 8'hE5
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [SIZE-1:0] HOWMANY,
  input  logic [15:0]     FIFO_Q,
  input  logic            FIFO_EMPTY,
  output logic            FIFO_RDREQ,
  output logic [31:0]     M_TDATA,
  output logic            M_TVALID,
  input  logic            M_TREADY,
  output logic            M_TLAST,
  output logic [15:0]     EVT_COUNT,
  output logic            ERR_TIMEOUT,
  output logic            BUSY
);

  localparam int            SW         = $clog2(TIMEOUT) + 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR_WAIT,
    HDR_SEND,
    S_FETCH,
    S_WAIT,
    BEAT_SEND
  } state_t;

  state_t          state;
  // FIFO_Q carries valid data in the cycle after a pop request
  logic            q_vld_p1;
  logic [SIZE-1:0] n_total;
  logic [SIZE-1:0] idx;
  logic [SIZE-1:0] idx_inc;
  // Low half of the beat under construction; the high-half sample is written
  // straight into the outgoing beat register when it arrives
  logic [WIDTH-1:0] lo_slot;
  logic [WIDTH-1:0] sample;
  logic [SW-1:0]    stall_cnt;
  logic             aborting;
  logic             handshake;
  logic             unused_ok;

  function automatic logic [15:0] zext(input logic [WIDTH-1:0] v);
    logic [15:0] r;
    r          = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] pack_beat(input logic [WIDTH-1:0] hi,
                                            input logic [WIDTH-1:0] lo);
    return {zext(hi), zext(lo)};
  endfunction

  // Bit 15 of the header word is ignored; framing is positional only
  function automatic logic [31:0] pack_header(input logic [14:0] w);
    return {MAGIC, 5'b0, w[14:12], 4'b0, w[11:0]};
  endfunction

  assign idx_inc   = idx + SIZE'(1);
  assign sample    = FIFO_Q[WIDTH-1:0];
  assign handshake = M_TVALID & M_TREADY;
  assign BUSY      = (state != IDLE);
  // Bit 15 of every data word carries no meaning for this block
  assign unused_ok = &{1'b0, FIFO_Q[15]};

  // Record parser / beat packer FSM with registered stream and FIFO outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      FIFO_RDREQ  <= 1'b0;
      q_vld_p1    <= 1'b0;
      M_TVALID    <= 1'b0;
      M_TLAST     <= 1'b0;
      M_TDATA     <= '0;
      EVT_COUNT   <= '0;
      ERR_TIMEOUT <= 1'b0;
      n_total     <= '0;
      idx         <= '0;
      lo_slot     <= '0;
      stall_cnt   <= '0;
      aborting    <= 1'b0;
    end else begin
      FIFO_RDREQ <= 1'b0;
      q_vld_p1   <= FIFO_RDREQ;
      unique case (state)
        IDLE: begin
          if (!FIFO_EMPTY) begin
            FIFO_RDREQ <= 1'b1;
            state      <= HDR_WAIT;
          end
        end

        HDR_WAIT: begin
          if (q_vld_p1) begin
            n_total  <= HOWMANY;
            idx      <= '0;
            lo_slot  <= '0;
            M_TDATA  <= pack_header(FIFO_Q[14:0]);
            M_TLAST  <= (HOWMANY == '0);
            M_TVALID <= 1'b1;
            state    <= HDR_SEND;
          end
        end

        HDR_SEND: begin
          if (handshake) begin
            M_TVALID <= 1'b0;
            M_TLAST  <= 1'b0;
            if (n_total == '0) begin
              EVT_COUNT <= EVT_COUNT + 16'd1;
              state     <= IDLE;
            end else begin
              stall_cnt <= '0;
              state     <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (!FIFO_EMPTY) begin
            FIFO_RDREQ <= 1'b1;
            stall_cnt  <= '0;
            state      <= S_WAIT;
          end else if (stall_cnt == STALL_LAST) begin
            // Stalled too long: flush any half-built beat (or an empty one)
            // as the record's last beat and give up on this record
            ERR_TIMEOUT <= 1'b1;
            aborting    <= 1'b1;
            M_TDATA     <= idx[0] ? pack_beat('0, lo_slot) : 32'h0;
            M_TLAST     <= 1'b1;
            M_TVALID    <= 1'b1;
            state       <= BEAT_SEND;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end

        S_WAIT: begin
          if (q_vld_p1) begin
            idx <= idx_inc;
            if (!idx[0]) begin
              lo_slot <= sample;
            end
            if (idx[0] || (idx_inc == n_total)) begin
              M_TDATA  <= idx[0] ? pack_beat(sample, lo_slot) : pack_beat('0, sample);
              M_TLAST  <= (idx_inc == n_total);
              M_TVALID <= 1'b1;
              state    <= BEAT_SEND;
            end else begin
              stall_cnt <= '0;
              state     <= S_FETCH;
            end
          end
        end

        BEAT_SEND: begin
          if (handshake) begin
            M_TVALID <= 1'b0;
            M_TLAST  <= 1'b0;
            lo_slot  <= '0;
            if (aborting) begin
              aborting <= 1'b0;
              state    <= IDLE;
            end else if (idx < n_total) begin
              stall_cnt <= '0;
              state     <= S_FETCH;
            end else begin
              EVT_COUNT <= EVT_COUNT + 16'd1;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_event_unpacker.sv
// tb_fifo_event_unpacker
// Randomized bench: a FIFO model feeds header/sample words, a record-level
// model predicts the 32-bit beats, and one monitor compares every cycle.
module tb_fifo_event_unpacker;

  localparam int SIZE    = 8;
  localparam int WIDTH   = 12;
  localparam int TMO     = 16;
  localparam int DEPTH   = 4096;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        abort;
  } beat_t;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b1;
  logic [SIZE-1:0] HOWMANY = '0;
  logic [15:0]     FIFO_Q = '0;
  logic            FIFO_EMPTY = 1'b1;
  logic            FIFO_RDREQ;
  logic [31:0]     M_TDATA;
  logic            M_TVALID;
  logic            M_TREADY = 1'b1;
  logic            M_TLAST;
  logic [15:0]     EVT_COUNT;
  logic            ERR_TIMEOUT;
  logic            BUSY;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          last_pop_cyc = 0;
  int          abort_cyc = -1;
  int          beats_seen = 0;
  logic        throttle = 1'b0;
  logic [15:0] mem [DEPTH];
  logic [15:0] smp_q [$];
  beat_t       exp_q [$];
  logic [31:0] got_q [$];
  logic [15:0] exp_evt = '0;
  logic        exp_err = 1'b0;

  fifo_event_unpacker #(
    .SIZE(SIZE), .WIDTH(WIDTH), .TIMEOUT(TMO), .MAGIC(8'hE5)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .HOWMANY(HOWMANY), .FIFO_Q(FIFO_Q),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RDREQ(FIFO_RDREQ), .M_TDATA(M_TDATA),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TLAST(M_TLAST),
    .EVT_COUNT(EVT_COUNT), .ERR_TIMEOUT(ERR_TIMEOUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Normal-mode FIFO: data appears the cycle after a pop; reset drops contents
  always @(posedge CLK) begin
    int r;
    r = rd_ptr;
    if (!RST_N) begin
      r = wr_ptr;
    end else if (FIFO_RDREQ && (r != wr_ptr)) begin
      FIFO_Q       <= mem[r[11:0]];
      r            = r + 1;
      last_pop_cyc <= cyc;
    end
    rd_ptr     <= r;
    FIFO_EMPTY <= (r == wr_ptr);
  end

  // Sink readiness, optionally throttled at random
  always @(posedge CLK) begin
    #2;
    M_TREADY = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr[11:0]] = w;
    wr_ptr++;
  endtask

  // Record-level model: header beat, then samples paired low/high, odd tail
  // zero-padded; a stalled record ends with its partial (or an empty) beat.
  function automatic void build_expected(input logic [15:0] hdr, input int n, input int avail);
    beat_t b;
    logic [15:0] lo, hi;
    b.data  = {8'hE5, 5'b0, hdr[14:12], 4'b0, hdr[11:0]};
    b.last  = (n == 0);
    b.abort = 1'b0;
    exp_q.push_back(b);
    if (avail >= n) begin
      for (int i = 0; i < n; i += 2) begin
        lo = smp_q[i] & 16'h0FFF;
        hi = (i + 1 < n) ? (smp_q[i+1] & 16'h0FFF) : 16'h0;
        b.data = {hi, lo}; b.last = (i + 2 >= n); b.abort = 1'b0;
        exp_q.push_back(b);
      end
    end else begin
      for (int i = 0; i + 1 < avail; i += 2) begin
        b.data = {smp_q[i+1] & 16'h0FFF, smp_q[i] & 16'h0FFF};
        b.last = 1'b0; b.abort = 1'b0;
        exp_q.push_back(b);
      end
      b.data  = (avail % 2 == 1) ? {16'h0, smp_q[avail-1] & 16'h0FFF} : 32'h0;
      b.last  = 1'b1;
      b.abort = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  task automatic fill_random(input int n);
    smp_q.delete();
    for (int i = 0; i < n; i++) smp_q.push_back(16'($urandom));
  endtask

  task automatic wait_drain(input int limit);
    for (int c = 0; c < limit && exp_q.size() > 0; c++) tick();
    chk("drain_beats_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Feeds one record (exp_q already built by the caller) and waits it out
  task automatic run_record(input logic [15:0] hdr, input int n, input int avail, input bit gaps);
    int b0;
    b0 = beats_seen;
    HOWMANY = 8'(n);
    push(hdr);
    for (int i = 0; i < avail; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      push(smp_q[i]);
    end
    for (int c = 0; c < 400 && beats_seen == b0; c++) tick();
    HOWMANY = 8'($urandom);
    wait_drain(4000);
    repeat (3) tick();
    chk("busy_after_record", 32'(BUSY), 32'd0);
    chk("words_all_popped", 32'(rd_ptr), 32'(wr_ptr));
  endtask

  task automatic check_reset_values();
    chk("rst_rdreq", 32'(FIFO_RDREQ), 32'd0);
    chk("rst_tvalid", 32'(M_TVALID), 32'd0);
    chk("rst_tlast", 32'(M_TLAST), 32'd0);
    chk("rst_tdata", M_TDATA, 32'd0);
    chk("rst_evt", 32'(EVT_COUNT), 32'd0);
    chk("rst_err", 32'(ERR_TIMEOUT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
  endtask

  task automatic monitor();
    logic        prev_stall;
    logic        prev_rd;
    logic        prev_last;
    logic [31:0] prev_data;
    beat_t       e;
    prev_stall = 1'b0; prev_rd = 1'b0; prev_last = 1'b0; prev_data = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_stall = 1'b0;
        prev_rd    = 1'b0;
      end else begin
        if (M_TVALID && exp_q.size() > 0 && exp_q[0].abort) begin
          exp_err = 1'b1;
          if (abort_cyc < 0) abort_cyc = cyc;
        end
        chk("evt_count", 32'(EVT_COUNT), 32'(exp_evt));
        chk("err_timeout", 32'(ERR_TIMEOUT), 32'(exp_err));
        if (FIFO_RDREQ) begin
          chk("rdreq_while_empty", 32'(FIFO_EMPTY), 32'd0);
          chk("rdreq_outstanding", 32'(prev_rd), 32'd0);
        end
        if (prev_stall) begin
          chk("hold_tvalid", 32'(M_TVALID), 32'd1);
          chk("hold_tdata", M_TDATA, prev_data);
          chk("hold_tlast", 32'(M_TLAST), 32'(prev_last));
        end
        if (M_TVALID && M_TREADY) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected no beat (t=%0t)", M_TDATA, $time);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", M_TDATA, e.data);
            chk("beat_last", 32'(M_TLAST), 32'(e.last));
            if (e.last && !e.abort) exp_evt = exp_evt + 16'd1;
          end
          got_q.push_back(M_TDATA);
          beats_seen++;
        end
        prev_stall = M_TVALID && !M_TREADY;
        prev_data  = M_TDATA;
        prev_last  = M_TLAST;
        prev_rd    = FIFO_RDREQ;
      end
    end
  endtask

  task automatic stimulus();
    logic [15:0] evt0;
    logic [15:0] hdr;
    int n;
    #1 RST_N = 1'b0;
    repeat (3) tick();
    check_reset_values();
    RST_N = 1'b1;
    repeat (2) tick();

    // Basic record: pin the model, then the DUT
    smp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    build_expected(16'h3ABC, 4, 4);
    chk("model_hdr", exp_q[0].data, 32'hE503_0ABC);
    chk("model_b1", exp_q[1].data, 32'h0002_0001);
    chk("model_b2", exp_q[2].data, 32'h0004_0003);
    chk("model_b2_last", 32'(exp_q[2].last), 32'd1);
    got_q.delete();
    run_record(16'h3ABC, 4, 4, 1'b0);
    chk("t1_hdr", got_q[0], 32'hE503_0ABC);
    chk("t1_b1", got_q[1], 32'h0002_0001);
    chk("t1_b2", got_q[2], 32'h0004_0003);
    chk("t1_evt", 32'(EVT_COUNT), 32'd1);

    // Odd count: final beat carries one sample, upper nibbles ignored
    smp_q = '{16'hFFFF, 16'h0FFF, 16'h8FFF};
    build_expected(16'hC123, 3, 3);
    got_q.delete();
    run_record(16'hC123, 3, 3, 1'b1);
    chk("t2_hdr", got_q[0], 32'hE504_0123);
    chk("t2_b1", got_q[1], 32'h0FFF_0FFF);
    chk("t2_b2", got_q[2], 32'h0000_0FFF);

    // Empty record: header only
    smp_q.delete();
    build_expected(16'h7001, 0, 0);
    got_q.delete();
    run_record(16'h7001, 0, 0, 1'b0);
    chk("t3_hdr", got_q[0], 32'hE507_0001);
    chk("t3_beats", 32'(got_q.size()), 32'd1);
    chk("t3_evt", 32'(EVT_COUNT), 32'd3);

    // Throttled sink, 8 records of 5 samples
    throttle = 1'b1;
    evt0 = EVT_COUNT;
    for (int r = 0; r < 8; r++) begin
      hdr = 16'($urandom);
      fill_random(5);
      build_expected(hdr, 5, 5);
      run_record(hdr, 5, 5, 1'b1);
    end
    chk("t4_evt_delta", 32'(EVT_COUNT - evt0), 32'd8);

    // Random record lengths
    for (int r = 0; r < 10; r++) begin
      hdr = 16'($urandom);
      n = $urandom_range(0, 9);
      fill_random(n);
      build_expected(hdr, n, n);
      run_record(hdr, n, n, 1'b1);
    end
    throttle = 1'b0;

    // Stall: 1 of 4 samples delivered
    evt0 = EVT_COUNT;
    abort_cyc = -1;
    smp_q = '{16'hF123};
    build_expected(16'h2456, 4, 1);
    got_q.delete();
    run_record(16'h2456, 4, 1, 1'b0);
    chk("t5_abort_beat", got_q[1], 32'h0000_0123);
    chk("t5_beats", 32'(got_q.size()), 32'd2);
    chk("t5_err", 32'(ERR_TIMEOUT), 32'd1);
    chk("t5_evt_unchanged", 32'(EVT_COUNT), 32'(evt0));
    chk("t5_stall_latency", 32'(abort_cyc - last_pop_cyc), 32'(TMO + 2));

    // Parsing resumes after an abort; the error stays set
    fill_random(2);
    build_expected(16'h1FFF, 2, 2);
    run_record(16'h1FFF, 2, 2, 1'b0);
    chk("t6_err_sticky", 32'(ERR_TIMEOUT), 32'd1);

    // Reset in the middle of a record
    fill_random(6);
    build_expected(16'h5A5A, 6, 6);
    HOWMANY = 8'd6;
    n = beats_seen;
    push(16'h5A5A);
    for (int i = 0; i < 3; i++) push(smp_q[i]);
    for (int c = 0; c < 400 && beats_seen == n; c++) tick();
    repeat (2) tick();
    RST_N = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    exp_evt = '0;
    exp_err = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    smp_q = '{16'h0ABC, 16'h0DEF};
    build_expected(16'h6010, 2, 2);
    got_q.delete();
    run_record(16'h6010, 2, 2, 1'b0);
    chk("t7_hdr", got_q[0], 32'hE506_0010);
    chk("t7_b1", got_q[1], 32'h0DEF_0ABC);
    chk("t7_evt", 32'(EVT_COUNT), 32'd1);
    chk("t7_err", 32'(ERR_TIMEOUT), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog: time limit reached, got running expected finished");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
